// File: rtl/crop_roi_scheduler_pkg.sv
// Shared definitions for the crop ROI scheduler: controller state encoding,
// a width helper and the frame-size helper.
package crop_roi_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Ceiling log2, never less than 1 so a single-entry index still has a bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Number of accepted pixels that make up one input frame.
  function automatic int frame_pixels(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/crop_roi_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above the
// pointer, wrapping around. Purely combinational; the pointer lives upstream.
module crop_roi_scheduler_rr_arbiter
  import crop_roi_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  // Scan from the pointer upward and take the first valid requester.
  always_comb begin
    int idx;
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        winner_o     = IDX_W'(idx);
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crop_roi_scheduler.sv
// Crop ROI scheduler: arbitrates crop-box requests, clamps the winning box to
// the image, hands Y1/X1 to the crop stage and holds it for one full frame of
// accepted pixels before serving the next request.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a request; grant is combinational in this state
// ST_ISSUE  | Y1/X1 offered to the crop stage, each channel retires alone
// ST_STREAM | counting accepted input pixels of the owned frame
// ST_DONE   | one-cycle frame_done pulse, then back to ST_IDLE
module crop_roi_scheduler
  import crop_roi_scheduler_pkg::*;
#(
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int OUT_ROWS         = 20,
  parameter int OUT_COLS         = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int NUM_REQ          = 2,
  localparam int OWNER_W         = clog2_min1(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*IMG_ROW_BITWIDTH-1:0]   req_y,
  input  logic [NUM_REQ*IMG_COL_BITWIDTH-1:0]   req_x,
  output logic [IMG_ROW_BITWIDTH-1:0]           crop_Y1_TDATA,
  output logic                                  crop_Y1_TVALID,
  input  logic                                  crop_Y1_TREADY,
  output logic [IMG_COL_BITWIDTH-1:0]           crop_X1_TDATA,
  output logic                                  crop_X1_TVALID,
  input  logic                                  crop_X1_TREADY,
  input  logic                                  pix_TVALID,
  input  logic                                  pix_TREADY,
  output logic [OWNER_W-1:0]                    owner,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int FRAME_PIX = frame_pixels(IN_ROWS, IN_COLS);
  localparam int CNT_W     = clog2_min1(FRAME_PIX + 1);

  localparam logic [IMG_ROW_BITWIDTH-1:0] Y1_MAX   = IMG_ROW_BITWIDTH'(IN_ROWS - OUT_ROWS);
  localparam logic [IMG_COL_BITWIDTH-1:0] X1_MAX   = IMG_COL_BITWIDTH'(IN_COLS - OUT_COLS);
  localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(FRAME_PIX - 1);
  localparam logic [OWNER_W-1:0]          IDX_LAST = OWNER_W'(NUM_REQ - 1);

  state_e                      state_q, state_d;
  logic [IMG_ROW_BITWIDTH-1:0] y1_q, y1_d;
  logic [IMG_COL_BITWIDTH-1:0] x1_q, x1_d;
  logic                        yv_q, yv_d;
  logic                        xv_q, xv_d;
  logic [OWNER_W-1:0]          owner_q, owner_d;
  logic [OWNER_W-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [NUM_REQ-1:0]          grant;
  logic [OWNER_W-1:0]          winner;
  logic                        grant_any;
  logic [IMG_ROW_BITWIDTH-1:0] sel_y;
  logic [IMG_COL_BITWIDTH-1:0] sel_x;
  logic                        pix_hs;

  crop_roi_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner),
    .any_o    (grant_any)
  );

  assign sel_y  = req_y[winner*IMG_ROW_BITWIDTH +: IMG_ROW_BITWIDTH];
  assign sel_x  = req_x[winner*IMG_COL_BITWIDTH +: IMG_COL_BITWIDTH];
  assign pix_hs = pix_TVALID & pix_TREADY;

  // Next-state and grant logic; reset suppresses the combinational grant so
  // no requester is told it was accepted in a cycle that is being discarded.
  always_comb begin
    state_d   = state_q;
    y1_d      = y1_q;
    x1_d      = x1_q;
    yv_d      = yv_q;
    xv_d      = xv_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any && !reset) begin
          req_ready = grant;
          y1_d      = (sel_y > Y1_MAX) ? Y1_MAX : sel_y;
          x1_d      = (sel_x > X1_MAX) ? X1_MAX : sel_x;
          owner_d   = winner;
          ptr_d     = (winner == IDX_LAST) ? '0 : winner + 1'b1;
          yv_d      = 1'b1;
          xv_d      = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (crop_Y1_TREADY) yv_d = 1'b0;
        if (crop_X1_TREADY) xv_d = 1'b0;
        if (!yv_d && !xv_d) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (pix_hs) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y1_q    <= '0;
      x1_q    <= '0;
      yv_q    <= 1'b0;
      xv_q    <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y1_q    <= y1_d;
      x1_q    <= x1_d;
      yv_q    <= yv_d;
      xv_q    <= xv_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign crop_Y1_TDATA  = y1_q;
  assign crop_X1_TDATA  = x1_q;
  assign crop_Y1_TVALID = yv_q;
  assign crop_X1_TVALID = xv_q;
  assign owner          = owner_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_DONE);

endmodule
